// File: rtl/pattern_seq.sv
// pattern_seq: programmable pattern sequencer.
// A DEPTH-entry table of {flag, last, data} words is loaded through a write port and
// played out one entry per clock on registered data/flag/valid when start is accepted,
// either once (one-shot) or repeatedly (loop) until stopped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (also erases the table)
//   wr_en/wr_addr/wr_data table write port; wr_data = {flag, last, data}
//   start, stop           begin playback (IDLE only) / abort playback (stop wins)
//   mode_loop             0 = one-shot, 1 = loop; latched when start is accepted
//   data, flag, valid     current table entry, registered
//   busy                  high while entries are being played
//   done                  one-cycle pulse after a completed playback
//
// Optional feature: define PATSEQ_LOOP_CNT_EN to add input loop_cnt[7:0]; loop mode then
// plays exactly loop_cnt+1 passes and finishes with a done pulse like one-shot.
module pattern_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W+1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_loop,
`ifdef PATSEQ_LOOP_CNT_EN
  input  logic [7:0]        loop_cnt,
`endif
  output logic [DATA_W-1:0] data,
  output logic              flag,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // StLast is the final cycle of a finishing playback: the last entry is on the
  // outputs and the next edge returns to IDLE with done.
  typedef enum logic [1:0] {StIdle, StRun, StLast} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                loop_q, loop_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                flag_q, flag_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
`ifdef PATSEQ_LOOP_CNT_EN
  logic [7:0]          cnt_q, cnt_d;
`endif

  logic [DATA_W+1:0]   tbl_q [DEPTH];
  logic [DATA_W+1:0]   rd_entry;
  logic                end_of_pass;

  // Table storage; a read at the same edge as a write sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  assign rd_entry    = tbl_q[ptr_q];
  assign end_of_pass = rd_entry[DATA_W] | (&ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    loop_d  = loop_q;
    data_d  = '0;
    flag_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef PATSEQ_LOOP_CNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StRun;
          ptr_d   = '0;
          loop_d  = mode_loop;
`ifdef PATSEQ_LOOP_CNT_EN
          cnt_d   = loop_cnt;
`endif
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          data_d  = rd_entry[DATA_W-1:0];
          flag_d  = rd_entry[DATA_W+1];
          valid_d = 1'b1;
          if (end_of_pass) begin
            ptr_d = '0;
            if (!loop_q) begin
              state_d = StLast;
            end
`ifdef PATSEQ_LOOP_CNT_EN
            else if (cnt_q == 8'd0) begin
              state_d = StLast;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
`endif
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      StLast: begin
        state_d = StIdle;
        done_d  = ~stop;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      loop_q  <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATSEQ_LOOP_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      loop_q  <= loop_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef PATSEQ_LOOP_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign data  = data_q;
  assign flag  = flag_q;
  assign valid = valid_q;
  // Busy spans exactly the cycles that carry table entries, so it tracks valid.
  assign busy  = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Self-checking bench for pattern_seq: directed scenarios plus randomized tables,
// checked against a table-level model of playback.
module tb_pattern_seq;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [9:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode_loop = 1'b0;
`ifdef PATSEQ_LOOP_CNT_EN
  logic [7:0] loop_cnt = '0;
`endif
  logic [7:0] data;
  logic       flag, valid, busy, done;
  logic [11:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  // Model of the table and of one playback pass.
  logic [9:0] mem [DEPTH];
  logic [9:0] pass_q [$];

  pattern_seq #(
    .DATA_W(8),
    .ADDR_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .stop(stop),
    .mode_loop(mode_loop),
`ifdef PATSEQ_LOOP_CNT_EN
    .loop_cnt(loop_cnt),
`endif
    .data(data),
    .flag(flag),
    .valid(valid),
    .busy(busy),
    .done(done)
  );

  assign obs = {data, flag, valid, busy, done};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entries from 0 up to the first one with last set, or the whole table.
  function automatic void build_pass();
    pass_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      pass_q.push_back(mem[i]);
      if (mem[i][8]) break;
    end
  endfunction

  // Expected {data, flag, valid, busy, done}.
  function automatic logic [11:0] exp_vec(input logic [9:0] e, input bit v, input bit d);
    exp_vec = {v ? e[7:0] : 8'h00, v ? e[9] : 1'b0, v, v, d};
  endfunction

  task automatic write_entry(input int a, input logic [9:0] v);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_data = v;
    step();
    wr_en   = 1'b0;
    mem[a]  = v;
  endtask

  // One-shot playback; with chain set, start is left high during the done cycle.
  task automatic run_oneshot(input string name, input bit chain);
    logic [11:0] e;
    build_pass();
    mode_loop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL %s accept-edge got %h want %h", name, obs, 12'h000);
    end
    for (int k = 0; k < pass_q.size(); k++) begin
      step();
      e = exp_vec(pass_q[k], 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s entry %0d got %h want %h", name, k, obs, e);
      end
    end
    step();
    e = exp_vec(10'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s done-cycle got %h want %h", name, obs, e);
    end
    if (chain) begin
      start = 1'b1;
    end else begin
      step();
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL %s after-done got %h want %h", name, obs, 12'h000);
      end
    end
  endtask

  // Loop playback of n outputs with start held high (must be ignored), then stop.
  task automatic run_loop_stop(input string name, input int n);
    logic [11:0] e;
    build_pass();
    mode_loop = 1'b1;
    start = 1'b1;
    step();
    mode_loop = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      e = exp_vec(pass_q[k % pass_q.size()], 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s output %0d got %h want %h", name, k, obs, e);
      end
    end
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL %s after-stop %0d got %h want %h", name, k, obs, 12'h000);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset got %h want %h", obs, 12'h000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL idle %0d got %h want %h", k, obs, 12'h000);
      end
    end
  endtask

  task automatic test_oneshot_short();
    write_entry(0, {1'b1, 1'b0, 8'h07});
    write_entry(1, {1'b1, 1'b0, 8'h02});
    write_entry(2, {1'b1, 1'b1, 8'h05});
    run_oneshot("oneshot_short", 1'b0);
  endtask

  task automatic test_full_table();
    for (int i = 0; i < DEPTH; i++) write_entry(i, {2'b00, 8'(8'h10 + i)});
    run_oneshot("full_table", 1'b0);
  endtask

  task automatic test_loop_stop();
    write_entry(0, {2'b00, 8'hA5});
    write_entry(1, {2'b01, 8'h5A});
    run_loop_stop("loop_stop", 5);
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop = 1'b1;
    mode_loop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL start_stop_idle %0d got %h want %h", k, obs, 12'h000);
      end
    end
    start = 1'b0;
    stop = 1'b0;
    mode_loop = 1'b0;
  endtask

  task automatic test_collision();
    logic [11:0] e;
    write_entry(0, {2'b00, 8'h11});
    write_entry(1, {2'b01, 8'h22});
    mode_loop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    // Entry 1 is read at the next edge; overwrite it at that same edge.
    wr_en = 1'b1;
    wr_addr = 3'd1;
    wr_data = {2'b01, 8'h33};
    step();
    wr_en = 1'b0;
    e = exp_vec({2'b01, 8'h22}, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL collision old got %h want %h", obs, e);
    end
    step();
    step();
    e = exp_vec({2'b01, 8'h33}, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL collision new got %h want %h", obs, e);
    end
    mem[1] = {2'b01, 8'h33};
    stop = 1'b1;
    step();
    stop = 1'b0;
    mode_loop = 1'b0;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL collision stop got %h want %h", obs, 12'h000);
    end
  endtask

  task automatic test_back_to_back();
    write_entry(0, {1'b1, 1'b0, 8'h07});
    write_entry(1, {1'b1, 1'b0, 8'h02});
    write_entry(2, {1'b1, 1'b1, 8'h05});
    run_oneshot("b2b_first", 1'b1);
    run_oneshot("b2b_second", 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        write_entry(i, {1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom)});
      end
      if ($urandom_range(0, 1) == 1) run_oneshot("rand_oneshot", 1'b0);
      else run_loop_stop("rand_loop", int'($urandom_range(1, 20)));
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < DEPTH; i++) write_entry(i, {2'b10, 8'(8'hC0 + i)});
    mode_loop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset got %h want %h", obs, 12'h000);
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    step();
    rst_n = 1'b1;
    step();
    run_oneshot("erased_table", 1'b0);
  endtask

`ifdef PATSEQ_LOOP_CNT_EN
  task automatic test_loop_cnt();
    logic [11:0] e;
    write_entry(0, {1'b1, 1'b0, 8'h07});
    write_entry(1, {1'b1, 1'b0, 8'h02});
    write_entry(2, {1'b1, 1'b1, 8'h05});
    build_pass();
    loop_cnt = 8'd2;
    mode_loop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    mode_loop = 1'b0;
    loop_cnt = 8'd0;
    for (int k = 0; k < 3 * pass_q.size(); k++) begin
      step();
      e = exp_vec(pass_q[k % pass_q.size()], 1'b1, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL loop_cnt output %0d got %h want %h", k, obs, e);
      end
    end
    step();
    e = exp_vec(10'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL loop_cnt done got %h want %h", obs, e);
    end
    step();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL loop_cnt after-done got %h want %h", obs, 12'h000);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot_short();
    test_full_table();
    test_loop_stop();
    test_start_stop_idle();
    test_collision();
    test_back_to_back();
    test_random();
`ifdef PATSEQ_LOOP_CNT_EN
    test_loop_cnt();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_seq.md
# pattern_seq

Parametrised, programmable pattern sequencer: a DEPTH-entry table of `{flag, last, data}` words is written through a simple write port. On `start`, the table is played out one entry per clock on registered `data`/`flag`/`valid` outputs, either once or looping until stopped. It drives timed test patterns and strobes into downstream blocks in the class designs, replacing fixed hard-coded case sequences.

## Interface
- DATA_W, 8: width of `data` and of the table data field
- ADDR_W, 3: table address width; DEPTH = 2**ADDR_W entries
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  table write strobe
- wr_addr  input  ADDR_W  table entry to write
- wr_data  input  DATA_W+2  entry: bit DATA_W+1 = flag, bit DATA_W = last, [DATA_W-1:0] = data
- start  input  1  begin playback (level sampled, acts only in IDLE)
- stop  input  1  abort playback
- mode_loop  input  1  0 = one-shot, 1 = loop; sampled when start is accepted
- data  output  DATA_W  current entry data
- flag  output  1  current entry flag
- valid  output  1  data/flag carry a table entry this cycle
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse at end of a completed playback

## Operation
- Reset (async, rst_n=0): state IDLE, ptr=0, all table entries 0; data=0, flag=0, valid=0, busy=0, done=0.
- Table write: at a rising edge with wr_en=1, entry[wr_addr] <= wr_data. Writes are legal in any state.
- Read/write collision: if an entry is read and written in the same edge, the output takes the old contents.
- States:
  - IDLE -> RUN when start=1 and stop=0. ptr <= 0; mode_loop is latched.
  - RUN: each edge registers entry[ptr] onto data/flag with valid=1.
    - End of pass: entry last=1, or ptr = DEPTH-1.
    - At end of pass with loop latched = 1, ptr wraps to 0 with no gap cycle.
    - At end of pass with loop latched = 0, the next edge goes to IDLE with done=1 and valid/data/flag=0.
  - RUN with stop=1: the next edge goes to IDLE; data/flag/valid are cleared and done stays 0.
- start while in RUN is ignored. If start and stop are both high in IDLE, stop wins and the block stays IDLE.
- Outside RUN: data=0, flag=0, valid=0.
- busy=1 exactly while in RUN.
- done is high for one cycle only.

## Timing
- start accepted at edge T:
  - entry k appears on outputs from edge T+1+k.
  - busy rises at T+1.
- One-shot pass of L entries:
  - last entry is output at T+L.
  - done=1 and busy=0 from edge T+1+L, for one cycle.
- Back-to-back start: start high during the done cycle is accepted; entry 0 appears the following cycle.
- stop sampled at edge S: outputs are 0 from S onward; busy is 0 from S.
- Reset asserted mid-RUN: outputs clear immediately (asynchronously) and the table is erased.

## Configuration
- PATSEQ_LOOP_CNT_EN defined:
  - adds input `loop_cnt` [7:0], latched together with mode_loop at start.
  - in loop mode, exactly loop_cnt+1 passes are played, then done pulses as in one-shot.
  - loop_cnt=255 means 256 passes.
  - one-shot mode ignores loop_cnt.
- PATSEQ_LOOP_CNT_EN not defined:
  - no `loop_cnt` port.
  - loop mode runs until stop or reset; done never pulses in loop mode.

## Test plan
- Reset, then idle for 10 cycles -> data=0x00, flag=0, valid=0, busy=0, done=0 throughout.
- Program entries 0..2 = {1,0,0x07}, {1,0,0x02}, {1,1,0x05}; start one-shot at T -> data 07,02,05 with flag=1, valid=1 at T+1..T+3; done=1 at T+4; busy=0 at T+4.
- Program all 8 entries with last=0, data = 0x10+i; one-shot -> 0x10..0x17 in order, then done after 0x17.
- Entries 0,1 = 0xA5, 0x5A, last set on entry 1; loop mode; stop after 5 outputs -> A5,5A,A5,5A,A5, then outputs 0 and done never asserts.
- Write entry 1 = 0x33 while it is being read, with prior value 0x22 -> output 0x22 that cycle, 0x33 on the next pass.
- With PATSEQ_LOOP_CNT_EN, loop_cnt=2 on the 3-entry table -> 9 valid outputs (07,02,05 ×3), then a done pulse; async reset mid-pass -> all outputs 0 at once.
